// File: rtl/sat_accumulator.sv
// Multi-channel signed saturating accumulator: 2-stage pipeline, per-channel
// accumulators, selectable symmetric negative clamp, wrap mode, sticky overflow flags.
module sat_accumulator #(
  parameter int N       = 16,
  parameter int CH      = 4,
  parameter bit SYM_SAT = 1'b1,
  localparam int CW     = $clog2(CH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [CW-1:0] in_ch,
  input  logic [N-1:0]  in_data,
  input  logic          in_clear,
  input  logic          sat_en,
  input  logic          ovf_clr,
  output logic          out_valid,
  output logic [CW-1:0] out_ch,
  output logic [N-1:0]  out_data,
  output logic          out_ovf,
  output logic [CH-1:0] ovf_sticky
);

  localparam logic [N-1:0] POS_MAX   = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] NEG_MIN   = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] NEG_SYM   = {1'b1, {(N-2){1'b0}}, 1'b1};
  localparam logic [N-1:0] NEG_CLAMP = SYM_SAT ? NEG_SYM : NEG_MIN;

  // Stage 1 registers
  logic          s1_valid_q, s1_valid_d;
  logic [CW-1:0] s1_ch_q, s1_ch_d;
  logic [N-1:0]  s1_data_q, s1_data_d;
  logic          s1_clear_q, s1_clear_d;
  logic          s1_sat_q, s1_sat_d;

  // Accumulators, output and flag registers
  logic [CH-1:0][N-1:0] acc_q, acc_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] out_ch_q, out_ch_d;
  logic [N-1:0]  out_data_q, out_data_d;
  logic          out_ovf_q, out_ovf_d;
  logic [CH-1:0] sticky_q, sticky_d;

  logic [N-1:0] acc_cur, raw, res;
  logic         ovf, res_ovf;

  always_comb begin
    s1_valid_d = in_valid && (32'(in_ch) < 32'(CH));
    s1_ch_d    = in_ch;
    s1_data_d  = in_data;
    s1_clear_d = in_clear;
    s1_sat_d   = sat_en;
  end

  always_comb begin
    acc_cur = acc_q[s1_ch_q];
    raw     = s1_clear_q ? s1_data_q : acc_cur + s1_data_q;
    ovf     = !s1_clear_q && (acc_cur[N-1] == s1_data_q[N-1]) && (raw[N-1] != acc_cur[N-1]);
    res     = raw;
    res_ovf = ovf;
    if (s1_sat_q) begin
      if (ovf) begin
        res = acc_cur[N-1] ? NEG_CLAMP : POS_MAX;
      end else if (SYM_SAT && (raw == NEG_MIN)) begin
        // the one value outside the symmetric range is pulled in and reported
        res     = NEG_SYM;
        res_ovf = 1'b1;
      end
    end
  end

  always_comb begin
    acc_d       = acc_q;
    out_valid_d = s1_valid_q;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    sticky_d    = ovf_clr ? '0 : sticky_q;
    if (s1_valid_q) begin
      acc_d[s1_ch_q] = res;
      out_ch_d       = s1_ch_q;
      out_data_d     = res;
      out_ovf_d      = res_ovf;
      // a set on the same edge as ovf_clr takes priority for that channel
      if (res_ovf) sticky_d[s1_ch_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_ch_q     <= '0;
      s1_data_q   <= '0;
      s1_clear_q  <= 1'b0;
      s1_sat_q    <= 1'b0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      sticky_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_ch_q     <= s1_ch_d;
      s1_data_q   <= s1_data_d;
      s1_clear_q  <= s1_clear_d;
      s1_sat_q    <= s1_sat_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      sticky_q    <= sticky_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_ch     = out_ch_q;
  assign out_data   = out_data_q;
  assign out_ovf    = out_ovf_q;
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_sat_accumulator.sv
// Scoreboard bench for sat_accumulator (N=8, CH=4); a SYM_SAT=0 twin shares the inputs.
module tb_sat_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] in_ch;
  logic [7:0] in_data;
  logic       in_clear;
  logic       sat_en;
  logic       ovf_clr;

  logic       out_valid, out_valid0;
  logic [1:0] out_ch, out_ch0;
  logic [7:0] out_data, out_data0;
  logic       out_ovf, out_ovf0;
  logic [3:0] ovf_sticky, ovf_sticky0;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic [1:0]  ch;
    logic [7:0]  d;
    logic        o;
    logic [7:0]  d0;
    logic        o0;
    logic [3:0]  st;
    int unsigned cyc;
  } exp_t;

  exp_t exp_q[$];

  sat_accumulator #(.N(8), .CH(4), .SYM_SAT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
    .in_clear(in_clear), .sat_en(sat_en), .ovf_clr(ovf_clr),
    .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data), .out_ovf(out_ovf),
    .ovf_sticky(ovf_sticky)
  );

  sat_accumulator #(.N(8), .CH(4), .SYM_SAT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
    .in_clear(in_clear), .sat_en(sat_en), .ovf_clr(ovf_clr),
    .out_valid(out_valid0), .out_ch(out_ch0), .out_data(out_data0), .out_ovf(out_ovf0),
    .ovf_sticky(ovf_sticky0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [1:0] ch, input logic [7:0] data, input logic clear,
                      input logic sat, input logic clr, input logic [7:0] d, input logic o,
                      input logic [7:0] d0, input logic o0, input logic [3:0] st);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1; in_ch = ch; in_data = data; in_clear = clear;
    sat_en = sat; ovf_clr = clr;
    e.ch = ch; e.d = d; e.o = o; e.d0 = d0; e.o0 = o0; e.st = st; e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic clr);
    @(negedge clk);
    in_valid = 1'b0; in_clear = 1'b0; ovf_clr = clr;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"},  32'(out_valid),  0);
    chk({tag, "_ch"},     32'(out_ch),     0);
    chk({tag, "_data"},   32'(out_data),   0);
    chk({tag, "_ovf"},    32'(out_ovf),    0);
    chk({tag, "_sticky"}, 32'(ovf_sticky), 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      chk("twin_valid", 32'(out_valid0), 32'(out_valid));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got out_valid=1 ch=%0d data=%0h expected no output",
                   out_ch, out_data);
        end else begin
          e = exp_q.pop_front();
          chk("latency",  cyc,               e.cyc + 2);
          chk("out_ch",   32'(out_ch),       32'(e.ch));
          chk("out_data", 32'(out_data),     32'(e.d));
          chk("out_ovf",  32'(out_ovf),      32'(e.o));
          chk("sticky",   32'(ovf_sticky),   32'(e.st));
          chk("data_sym0", 32'(out_data0),   32'(e.d0));
          chk("ovf_sym0",  32'(out_ovf0),    32'(e.o0));
        end
      end
    end
  end

  initial begin
    int unsigned wait_cnt;
    rst_n = 1'b0; in_valid = 1'b0; in_ch = '0; in_data = '0;
    in_clear = 1'b0; sat_en = 1'b1; ovf_clr = 1'b0;
    @(negedge clk);
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // leave a nonzero result behind, then reset with a sample sitting in S1
    send(2'd0, 8'h14, 1'b1, 1'b1, 1'b0, 8'h14, 1'b0, 8'h14, 1'b0, 4'b0000);
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);
    in_valid = 1'b1; in_ch = 2'd0; in_data = 8'h07; in_clear = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;

    //   ch    data   clr   sat   oclr  d      o     d0     o0    sticky
    send(2'd0, 8'h05, 1'b0, 1'b1, 1'b0, 8'h05, 1'b0, 8'h05, 1'b0, 4'b0000);
    send(2'd0, 8'h64, 1'b1, 1'b1, 1'b0, 8'h64, 1'b0, 8'h64, 1'b0, 4'b0000);
    send(2'd0, 8'h32, 1'b0, 1'b1, 1'b0, 8'h7F, 1'b1, 8'h7F, 1'b1, 4'b0001);
    send(2'd1, 8'h9C, 1'b1, 1'b1, 1'b0, 8'h9C, 1'b0, 8'h9C, 1'b0, 4'b0001);
    send(2'd1, 8'h9C, 1'b0, 1'b1, 1'b0, 8'h81, 1'b1, 8'h80, 1'b1, 4'b0011);
    send(2'd1, 8'h80, 1'b1, 1'b1, 1'b0, 8'h81, 1'b1, 8'h80, 1'b0, 4'b0011);
    send(2'd2, 8'h64, 1'b1, 1'b0, 1'b0, 8'h64, 1'b0, 8'h64, 1'b0, 4'b0011);
    send(2'd2, 8'h32, 1'b0, 1'b0, 1'b0, 8'h96, 1'b1, 8'h96, 1'b1, 4'b0111);
    send(2'd0, 8'h10, 1'b1, 1'b1, 1'b0, 8'h10, 1'b0, 8'h10, 1'b0, 4'b0111);
    send(2'd3, 8'h0A, 1'b0, 1'b1, 1'b0, 8'h0A, 1'b0, 8'h0A, 1'b0, 4'b0111);
    send(2'd3, 8'h0A, 1'b0, 1'b1, 1'b0, 8'h14, 1'b0, 8'h14, 1'b0, 4'b0111);
    send(2'd3, 8'h0A, 1'b0, 1'b1, 1'b0, 8'h1E, 1'b0, 8'h1E, 1'b0, 4'b0111);
    send(2'd3, 8'h0A, 1'b0, 1'b1, 1'b0, 8'h28, 1'b0, 8'h28, 1'b0, 4'b0111);
    send(2'd0, 8'h01, 1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 8'h11, 1'b0, 4'b0111);
    // ovf_clr rides with the next sample, landing on the edge that writes this overflow
    send(2'd0, 8'h7F, 1'b0, 1'b1, 1'b0, 8'h7F, 1'b1, 8'h7F, 1'b1, 4'b0001);
    send(2'd3, 8'h01, 1'b0, 1'b1, 1'b1, 8'h29, 1'b0, 8'h29, 1'b0, 4'b0000);
    idle(1'b1);
    idle(1'b0);

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    chk("queue_drained", exp_q.size(), 0);

    repeat (3) @(negedge clk);
    chk("hold_valid",  32'(out_valid),  0);
    chk("hold_ch",     32'(out_ch),     3);
    chk("hold_data",   32'(out_data),   32'h29);
    chk("hold_ovf",    32'(out_ovf),    0);
    chk("hold_sticky", 32'(ovf_sticky), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sat_accumulator.md
# sat_accumulator

Multi-channel signed saturating accumulator for the filter datapath. It extends our combinational saturating adder with per-channel state, a registered 2-stage pipeline and a valid handshake. It adds a selectable negative clamp, a wrap mode, and per-channel sticky overflow flags. It sits after the tap multipliers and accumulates products per filter channel, one sample per cycle, time-multiplexed across channels.

## Interface
- N, 16: data and accumulator width, two's complement, N ≥ 4.
- CH, 4: number of independent channel accumulators, CH ≥ 2; CW = $clog2(CH).
- SYM_SAT, 1: selects the negative clamp value.
  - 1: symmetric, −(2^(N−1)−1).
  - 0: full range, −2^(N−1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  sample present this cycle.
- in_ch  in  CW  target channel; values ≥ CH are ignored (sample dropped).
- in_data  in  N  signed addend.
- in_clear  in  1  with in_valid: load instead of accumulate.
- sat_en  in  1  1 = saturate on overflow, 0 = wrap mod 2^N.
- ovf_clr  in  1  clears all sticky flags.
- out_valid  out  1  result present.
- out_ch  out  CW  channel of result.
- out_data  out  N  new accumulator value of out_ch.
- out_ovf  out  1  this result overflowed or was clamped.
- ovf_sticky  out  CH  per-channel sticky overflow.

## Operation
- **Stage 1 (S1):** on each edge, S1 captures in_valid, in_ch, in_data, in_clear and sat_en.
  - An invalid channel index clears the S1 valid bit.
- **Stage 2 (S2):** computes from the S1 registers and the current acc[S1.ch]. On the next edge it writes acc[S1.ch] and the output registers.
- **Sum:**
  - Accumulate: raw = acc + data, N-bit.
  - Clear: raw = data.
- **Overflow:** ovf = (acc[N−1] == data[N−1]) && (raw[N−1] != acc[N−1]). Overflow is never flagged in clear mode.
- **Saturating result (sat_en=1):**
  - Positive overflow gives 2^(N−1)−1.
  - Negative overflow gives the SYM_SAT clamp value.
  - With SYM_SAT=1, a non-overflow raw of exactly −2^(N−1) (including a clear load of it) is also clamped to −(2^(N−1)−1) and flags out_ovf.
- **Wrap result (sat_en=0):** result = raw; out_ovf = ovf. The SYM_SAT clamp is not applied.
- **Write-back:** the written acc value equals out_data. Other channels are unchanged.
- **Sticky flags:**
  - ovf_sticky[ch] is set when a result with out_ovf=1 is written for ch.
  - ovf_clr clears all flags on the edge it is sampled.
  - If a set and ovf_clr occur on the same edge, the set wins for that channel.
- **No forwarding needed:** S2 writes acc on the same edge S1 captures the next sample, so back-to-back samples to the same channel read the updated value.

## Timing
- **Reset (rst_n low, asynchronous):**
  - All acc = 0 and the S1 valid bit = 0.
  - out_valid = 0, out_ch = 0, out_data = 0, out_ovf = 0, ovf_sticky = 0.
- **Reset mid-operation:** the in-flight S1 sample is discarded, with no write-back and no output.
- **Latency:** 2 cycles. A sample with in_valid high at edge k produces out_valid high for exactly one cycle after edge k+1.
- **Throughput:** 1 sample/cycle with no stalls. There is no ready signal, so the upstream block must not exceed 1/cycle.
- **Output hold:** out_data, out_ch and out_ovf hold their last values while out_valid=0.
- **Flag update:** ovf_sticky updates on the same edge as the corresponding out_valid.
- **Control sampling:** sat_en and in_clear are sampled per sample at S1 and are not re-read in S2.

## Test plan
(N=8, CH=4, SYM_SAT=1 unless noted)
- **Reset:** hold rst_n low mid-stream with a sample in S1 → all outputs 0, no out_valid pulse; after release, ch0 add 5 → out_data=5.
- **Positive saturation:** ch0 clear 100, then add 50 → out_data 100 (out_ovf=0), then 127 (out_ovf=1), ovf_sticky=4'b0001.
- **Negative clamp:** ch1 clear −100, add −100 → out_data −127 (0x81). With SYM_SAT=0 → −128 (0x80). With SYM_SAT=1, clear −128 → −127 and out_ovf=1.
- **Wrap mode:** sat_en=0, ch2 clear 100, add 50 → out_data −106 (0x96), out_ovf=1, ovf_sticky[2]=1.
- **Back-to-back and isolation:** ch3 +10 on 4 consecutive cycles, then ch0 +1 → outputs 10, 20, 30, 40 with out_ch=3 on consecutive cycles, 2-cycle latency; ch0 result = previous ch0 value + 1.
- **Sticky clear race:** ovf_clr pulsed on the same edge as a ch0 overflow write → ovf_sticky[0]=1 and other channels cleared. The next ovf_clr alone → ovf_sticky=0.
